// File: rtl/rv32e_wb_regfile.sv
// RV32E writeback stage and architectural register file.
// Arbitrates ALU results and load data onto one write port, parks a colliding
// ALU write in a single-entry pending slot, and serves two bypassed
// combinational read ports. x0 reads as zero and is never written.
module rv32e_wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 16,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_result,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            wb_valid,
  output logic [AW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data
);

  // Architectural state; entry 0 is held at zero and masked on reads.
  logic [XLEN-1:0] regs_reg [NREGS];

  logic            pend_valid_reg, pend_valid_next;
  logic [AW-1:0]   pend_rd_reg, pend_rd_next;
  logic [XLEN-1:0] pend_data_reg, pend_data_next;

  logic            wb_valid_reg;
  logic [AW-1:0]   wb_rd_reg;
  logic [XLEN-1:0] wb_data_reg;

  logic            mem_fire, alu_fire, kill;
  logic            wr_en, wr_commit;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  // Loads are never stalled; the ALU stalls only while a deferred write is parked.
  assign mem_ready = !rst;
  assign alu_ready = !rst && !pend_valid_reg;
  assign mem_fire  = mem_valid && mem_ready;
  assign alu_fire  = alu_valid && alu_ready;
  // A newer load to the same rd makes the parked ALU value dead.
  assign kill      = mem_fire && pend_valid_reg && (mem_rd == pend_rd_reg);
  assign wr_commit = wr_en && (wr_addr != '0);

  assign busy     = pend_valid_reg;
  assign wb_valid = wb_valid_reg;
  assign wb_rd    = wb_rd_reg;
  assign wb_data  = wb_data_reg;

  // Write-port arbitration (load > pending > ALU) and pending-slot next state.
  always_comb begin
    wr_en           = 1'b0;
    wr_addr         = '0;
    wr_data         = '0;
    pend_valid_next = pend_valid_reg;
    pend_rd_next    = pend_rd_reg;
    pend_data_next  = pend_data_reg;
    if (mem_fire) begin
      wr_en   = 1'b1;
      wr_addr = mem_rd;
      wr_data = mem_data;
      if (alu_fire) begin
        // alu_fire implies the slot was empty, so it can be loaded directly.
        pend_valid_next = 1'b1;
        pend_rd_next    = alu_rd;
        pend_data_next  = alu_result;
      end else if (kill) begin
        pend_valid_next = 1'b0;
      end
    end else if (pend_valid_reg) begin
      // Drains even when rd is 0, costing one cycle without an array write.
      wr_en           = 1'b1;
      wr_addr         = pend_rd_reg;
      wr_data         = pend_data_reg;
      pend_valid_next = 1'b0;
    end else if (alu_fire) begin
      wr_en   = 1'b1;
      wr_addr = alu_rd;
      wr_data = alu_result;
    end
  end

  // Pending slot and write trace registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_reg <= 1'b0;
      pend_rd_reg    <= '0;
      pend_data_reg  <= '0;
      wb_valid_reg   <= 1'b0;
      wb_rd_reg      <= '0;
      wb_data_reg    <= '0;
    end else begin
      pend_valid_reg <= pend_valid_next;
      pend_rd_reg    <= pend_rd_next;
      pend_data_reg  <= pend_data_next;
      wb_valid_reg   <= wr_commit;
      if (wr_commit) begin
        wb_rd_reg   <= wr_addr;
        wb_data_reg <= wr_data;
      end
    end
  end

  // Register array: cleared on reset, single write port, x0 never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_commit) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  // Two independent read ports, each bypassing in age order newest first.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      assign addr = (gi == 0) ? rs1_addr : rs2_addr;

      // Priority: x0, ALU this cycle, load this cycle, live pending, array.
      always_comb begin
        data = regs_reg[addr];
        if (addr == '0) begin
          data = '0;
        end else if (alu_fire && (alu_rd == addr)) begin
          data = alu_result;
        end else if (mem_fire && (mem_rd == addr)) begin
          data = mem_data;
        end else if (pend_valid_reg && !kill && (pend_rd_reg == addr)) begin
          data = pend_data_reg;
        end
      end
    end
  endgenerate

  assign rs1_data = g_read[0].data;
  assign rs2_data = g_read[1].data;

endmodule

// File: tb/tb_rv32e_wb_regfile.sv
// Directed table-driven bench for rv32e_wb_regfile. Each table row is one
// clock cycle: inputs driven after the rising edge, outputs compared on the
// falling edge against hand-computed values for that cycle.
module tb_rv32e_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [3:0]  alu_rd, mem_rd, rs1_addr, rs2_addr, wb_rd;
  logic [31:0] alu_result, mem_data, rs1_data, rs2_data, wb_data;
  logic        busy, wb_valid;

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_miss = 0;

  rv32e_wb_regfile #(.XLEN(32), .NREGS(16)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;
    logic [3:0]  ard;
    logic [31:0] ares;
    logic        mv;
    logic [3:0]  mrd;
    logic [31:0] mdat;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ear;
    logic        eb;
    logic        ewv;
    logic [3:0]  ewrd;
    logic [31:0] ewd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic av, logic [3:0] ard, logic [31:0] ares,
                              logic mv, logic [3:0] mrd, logic [31:0] mdat,
                              logic [3:0] r1, logic [3:0] r2, logic [31:0] e1, logic [31:0] e2,
                              logic ear, logic eb, logic ewv, logic [3:0] ewrd, logic [31:0] ewd);
    vec_t v;
    v.rst = r;  v.av = av; v.ard = ard; v.ares = ares;
    v.mv = mv;  v.mrd = mrd; v.mdat = mdat;
    v.r1 = r1;  v.r2 = r2; v.e1 = e1; v.e2 = e2;
    v.ear = ear; v.eb = eb; v.ewv = ewv; v.ewrd = ewrd; v.ewd = ewd;
    return v;
  endfunction

  task automatic cmp(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL row %0d %s: got %h expected %h", row, nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int row);
    rst = v.rst;
    alu_valid = v.av; alu_rd = v.ard; alu_result = v.ares;
    mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.mdat;
    rs1_addr = v.r1;  rs2_addr = v.r2;
    @(negedge clk);
    n_vec++;
    cmp("rs1_data",  row, rs1_data, v.e1);
    cmp("rs2_data",  row, rs2_data, v.e2);
    cmp("alu_ready", row, {31'd0, alu_ready}, {31'd0, v.ear});
    cmp("mem_ready", row, {31'd0, mem_ready}, {31'd0, ~v.rst});
    cmp("busy",      row, {31'd0, busy}, {31'd0, v.eb});
    cmp("wb_valid",  row, {31'd0, wb_valid}, {31'd0, v.ewv});
    cmp("wb_rd",     row, {28'd0, wb_rd}, {28'd0, v.ewrd});
    cmp("wb_data",   row, wb_data, v.ewd);
    $display("row %0d rst=%0d alu=%0d/%0d/%h mem=%0d/%0d/%h rs1[%0d]=%h rs2[%0d]=%h ar=%0d busy=%0d wb=%0d/%0d/%h",
             row, v.rst, v.av, v.ard, v.ares, v.mv, v.mrd, v.mdat, v.r1, rs1_data, v.r2, rs2_data,
             alu_ready, busy, wb_valid, wb_rd, wb_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst av ard ares          mv mrd mdat          r1 r2 e1            e2            ar b wv wrd wd
    // Reset: preload x5, then reset clears it
    tbl.push_back(mk(0, 1, 5, 32'h1234,     0, 0, 0,             5, 0, 32'h1234,     0,            1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,             5, 5, 32'h1234,     32'h1234,     1, 0, 1, 5, 32'h1234));
    tbl.push_back(mk(1, 1, 5, 32'hFFFF,     0, 0, 0,             5, 0, 32'h1234,     0,            0, 0, 0, 5, 32'h1234));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,             5, 0, 0,            0,            1, 0, 0, 0, 0));
    // Bypass and x0
    tbl.push_back(mk(0, 1, 3, 32'hDEADBEEF, 0, 0, 0,             3, 4, 32'hDEADBEEF, 0,            1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0,             3, 0, 32'hDEADBEEF, 0,            1, 0, 1, 3, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,             0, 3, 0,            32'hDEADBEEF, 1, 0, 0, 3, 32'hDEADBEEF));
    // Collision, different rd
    tbl.push_back(mk(0, 1, 6, 32'h5555,     1, 4, 32'hAAAA0000,  4, 6, 32'hAAAA0000, 32'h5555,     1, 0, 0, 3, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,             4, 6, 32'hAAAA0000, 32'h5555,     0, 1, 1, 4, 32'hAAAA0000));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,             6, 4, 32'h5555,     32'hAAAA0000, 1, 0, 1, 6, 32'h5555));
    // Collision, same rd: ALU is younger
    tbl.push_back(mk(0, 1, 7, 32'h2,        1, 7, 32'h1,         7, 7, 32'h2,        32'h2,        1, 0, 0, 6, 32'h5555));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,             7, 7, 32'h2,        32'h2,        0, 1, 1, 7, 32'h1));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,             7, 0, 32'h2,        0,            1, 0, 1, 7, 32'h2));
    // Kill: pending x9 overtaken by a newer load to x9
    tbl.push_back(mk(0, 1, 9, 32'h99,       1, 8, 32'h88,        9, 8, 32'h99,       32'h88,       1, 0, 0, 7, 32'h2));
    tbl.push_back(mk(0, 0, 0, 0,            1, 9, 32'h77,        9, 8, 32'h77,       32'h88,       0, 1, 1, 8, 32'h88));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,             9, 8, 32'h77,       32'h88,       1, 0, 1, 9, 32'h77));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,             9, 0, 32'h77,       0,            1, 0, 0, 9, 32'h77));
    // Pending entry with rd 0 drains without a trace pulse
    tbl.push_back(mk(0, 1, 0, 32'hABC,      1, 1, 32'h11,        1, 0, 32'h11,       0,            1, 0, 0, 9, 32'h77));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,             1, 0, 32'h11,       0,            0, 1, 1, 1, 32'h11));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,             1, 0, 32'h11,       0,            1, 0, 0, 1, 32'h11));
    // Starvation: pending x2 held while loads to x8 stream for 5 cycles
    tbl.push_back(mk(0, 1, 2, 32'h2222,     1, 8, 32'h800,       2, 8, 32'h2222,     32'h800,      1, 0, 0, 1, 32'h11));
    for (int k = 1; k <= 5; k++) begin
      tbl.push_back(mk(0, 1, 3, 32'hBAD, 1, 8, 32'h800 + k, 2, 8, 32'h2222, 32'h800 + k,
                       0, 1, 1, 8, 32'h800 + k - 1));
    end
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,             2, 8, 32'h2222,     32'h805,      0, 1, 1, 8, 32'h805));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,             2, 8, 32'h2222,     32'h805,      1, 0, 1, 2, 32'h2222));
    // Reset while a deferred write is parked
    tbl.push_back(mk(0, 1, 2, 32'h3333,     1, 8, 32'h900,       2, 8, 32'h3333,     32'h900,      1, 0, 0, 2, 32'h2222));
    tbl.push_back(mk(1, 0, 0, 0,            1, 8, 32'h901,       2, 8, 32'h3333,     32'h900,      0, 1, 1, 8, 32'h900));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,             2, 8, 0,            0,            1, 0, 0, 0, 0));

    // Initial reset: handshakes must be closed while rst is high.
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 4'd1; alu_result = 32'h1;
    mem_valid = 1'b1; mem_rd = 4'd1; mem_data = 32'h1;
    rs1_addr = 4'd0; rs2_addr = 4'd0;
    @(negedge clk);
    n_vec++;
    cmp("alu_ready_in_rst", -1, {31'd0, alu_ready}, 32'd0);
    cmp("mem_ready_in_rst", -1, {31'd0, mem_ready}, 32'd0);
    $display("row -1 rst=1 alu_ready=%0d mem_ready=%0d", alu_ready, mem_ready);
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
